// File: rtl/display_scan_driver.sv
// Two-digit multiplexed 7-segment driver for a latched 4-bit value (0..15).
// Scans units and tens with a one-cycle blank gap between them to avoid ghosting.
module display_scan_driver #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] Data_in,
    output logic [3:0] OUTbinario,
    output logic [6:0] outDisplay,
    output logic       an3,
    output logic       an4
);

    localparam int unsigned    CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]     SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        S_UNITS = 2'd0,
        S_GAP_A = 2'd1,
        S_TENS  = 2'd2,
        S_GAP_B = 2'd3
    } scan_state_t;

    scan_state_t      state, next_state;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [3:0]       value;
    logic             tens;
    logic [3:0]       units;

    // Active-low segment pattern {g,f,e,d,c,b,a} for a decimal digit.
    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        logic [6:0] code;
        unique case (digit)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values;
    // blocking assignments here would make results depend on process order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= 4'd0;
        end else if (load) begin
            value <= Data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_UNITS;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // NOTE: every always_comb output gets a default before the case; a missing
    // assignment on any path would infer a latch.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        unique case (state)
            S_UNITS: begin
                if (cnt == CNT_LAST) begin
                    next_state = S_GAP_A;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_GAP_A: begin
                next_state = S_TENS;
                cnt_next   = '0;
            end
            S_TENS: begin
                if (cnt == CNT_LAST) begin
                    next_state = S_GAP_B;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_GAP_B: begin
                next_state = S_UNITS;
                cnt_next   = '0;
            end
            default: begin
                next_state = S_UNITS;
                cnt_next   = '0;
            end
        endcase
    end

    // Digit split only ever sees 0..15, so tens is at most 1.
    always_comb begin
        tens  = (value >= 4'd10);
        units = tens ? (value - 4'd10) : value;
    end

    // Outputs decode purely from registered state; inputs never reach them directly.
    always_comb begin
        an3        = 1'b1;
        an4        = 1'b1;
        outDisplay = SEG_BLANK;
        unique case (state)
            S_UNITS: begin
                an4        = 1'b0;
                outDisplay = seg_code(units);
            end
            S_TENS: begin
                if (BLANK_LZ && !tens) begin
                    an3        = 1'b1;
                    outDisplay = SEG_BLANK;
                end else begin
                    an3        = 1'b0;
                    outDisplay = seg_code({3'b000, tens});
                end
            end
            default: begin
                an3        = 1'b1;
                an4        = 1'b1;
                outDisplay = SEG_BLANK;
            end
        endcase
    end

    assign OUTbinario = value;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed, table-driven bench for display_scan_driver with REFRESH_DIV=4 (and 3 for wrap).
module tb_display_scan_driver;

    localparam logic [6:0] C0 = 7'b1000000;
    localparam logic [6:0] C1 = 7'b1111001;
    localparam logic [6:0] C5 = 7'b0010010;
    localparam logic [6:0] C7 = 7'b1111000;
    localparam logic [6:0] BL = 7'b1111111;
    localparam int         NV = 34;

    typedef struct {
        logic       ld;
        logic [3:0] din;
        logic [3:0] bin;
        logic [6:0] seg;
        logic       a3;
        logic       a4;
        logic [6:0] seg_b;
        logic       a3_b;
    } vec_t;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [3:0] data_in = 4'd0;

    logic [3:0] bin0, bin1, bin2;
    logic [6:0] seg0, seg1, seg2;
    logic       an3_0, an4_0, an3_1, an4_1, an3_2, an4_2;

    int checks = 0;
    int errors = 0;
    vec_t vecs[NV];

    always #5 if (clk_en) clk = ~clk;

    display_scan_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut0 (
        .clk(clk), .rst(rst), .load(load), .Data_in(data_in),
        .OUTbinario(bin0), .outDisplay(seg0), .an3(an3_0), .an4(an4_0));

    display_scan_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut1 (
        .clk(clk), .rst(rst), .load(load), .Data_in(data_in),
        .OUTbinario(bin1), .outDisplay(seg1), .an3(an3_1), .an4(an4_1));

    display_scan_driver #(.REFRESH_DIV(3), .BLANK_LZ(1'b0)) dut2 (
        .clk(clk), .rst(rst), .load(load), .Data_in(data_in),
        .OUTbinario(bin2), .outDisplay(seg2), .an3(an3_2), .an4(an4_2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic ld, input logic [3:0] din, input logic [3:0] bin,
                                input logic [6:0] seg, input logic a3, input logic a4);
        vec_t v;
        v.ld = ld; v.din = din; v.bin = bin; v.seg = seg; v.a3 = a3; v.a4 = a4;
        v.seg_b = seg; v.a3_b = a3;
        return v;
    endfunction

    // Anodes must never both be low, whatever the phase.
    always @(negedge clk) begin
        if (rst) begin
            check("an_overlap0", {31'd0, an3_0 | an4_0}, 32'd1);
            check("an_overlap1", {31'd0, an3_1 | an4_1}, 32'd1);
            check("an_overlap2", {31'd0, an3_2 | an4_2}, 32'd1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Rows are the outputs seen just after edge k = index+1 after reset release.
        vecs[0] = mk(1, 4'd11, 4'd11, C1, 1, 0);
        for (int k = 1; k < 3; k++) vecs[k] = mk(0, 4'd11, 4'd11, C1, 1, 0);
        vecs[3] = mk(0, 4'd11, 4'd11, BL, 1, 1);
        for (int k = 4; k < 8; k++) vecs[k] = mk(0, 4'd11, 4'd11, C1, 0, 1);
        vecs[8] = mk(0, 4'd11, 4'd11, BL, 1, 1);
        for (int k = 9; k < 13; k++) vecs[k] = mk(0, 4'd15, 4'd11, C1, 1, 0);
        vecs[13] = mk(0, 4'd15, 4'd11, BL, 1, 1);
        for (int k = 14; k < 17; k++) vecs[k] = mk(0, 4'd15, 4'd11, C1, 0, 1);
        vecs[17] = mk(1, 4'd15, 4'd15, C1, 0, 1);
        vecs[18] = mk(0, 4'd15, 4'd15, BL, 1, 1);
        for (int k = 19; k < 23; k++) vecs[k] = mk(0, 4'd15, 4'd15, C5, 1, 0);
        vecs[23] = mk(0, 4'd15, 4'd15, BL, 1, 1);
        vecs[24] = mk(1, 4'd7, 4'd7, BL, 1, 1);
        for (int k = 25; k < 28; k++) vecs[k] = mk(0, 4'd7, 4'd7, BL, 1, 1);
        for (int k = 24; k < 28; k++) begin
            vecs[k].seg_b = C0;
            vecs[k].a3_b  = 1'b0;
        end
        vecs[28] = mk(0, 4'd7, 4'd7, BL, 1, 1);
        for (int k = 29; k < 33; k++) vecs[k] = mk(0, 4'd7, 4'd7, C7, 1, 0);
        vecs[33] = mk(0, 4'd7, 4'd7, BL, 1, 1);

        // Reset with the clock stopped.
        #3;
        check("rst_bin", {28'd0, bin0}, 32'd0);
        check("rst_seg", {25'd0, seg0}, {25'd0, C0});
        check("rst_an4", {31'd0, an4_0}, 32'd0);
        check("rst_an3", {31'd0, an3_0}, 32'd1);

        clk_en = 1'b1;
        repeat (2) tick();
        check("rst_hold_seg", {25'd0, seg0}, {25'd0, C0});
        rst = 1'b1;
        check("pre_edge1_an4", {31'd0, an4_0}, 32'd0);
        check("pre_edge1_seg", {25'd0, seg0}, {25'd0, C0});

        for (int i = 0; i < NV; i++) begin
            load    = vecs[i].ld;
            data_in = vecs[i].din;
            tick();
            check($sformatf("v%0d_bin", i + 1), {28'd0, bin0}, {28'd0, vecs[i].bin});
            check($sformatf("v%0d_seg", i + 1), {25'd0, seg0}, {25'd0, vecs[i].seg});
            check($sformatf("v%0d_an3", i + 1), {31'd0, an3_0}, {31'd0, vecs[i].a3});
            check($sformatf("v%0d_an4", i + 1), {31'd0, an4_0}, {31'd0, vecs[i].a4});
            check($sformatf("v%0d_seg_b", i + 1), {25'd0, seg1}, {25'd0, vecs[i].seg_b});
            check($sformatf("v%0d_an3_b", i + 1), {31'd0, an3_1}, {31'd0, vecs[i].a3_b});
        end

        // Load 11 as TENS begins, then async reset in the middle of TENS.
        load = 1'b1; data_in = 4'd11;
        tick();
        load = 1'b0;
        tick();
        check("tens11_an3", {31'd0, an3_0}, 32'd0);
        check("tens11_seg", {25'd0, seg0}, {25'd0, C1});
        #2;
        rst = 1'b0;
        #1;
        check("async_an3", {31'd0, an3_0}, 32'd1);
        check("async_an4", {31'd0, an4_0}, 32'd0);
        check("async_seg", {25'd0, seg0}, {25'd0, C0});
        check("async_bin", {28'd0, bin0}, 32'd0);
        tick();
        check("rst_held_an4", {31'd0, an4_1}, 32'd0);
        rst = 1'b1;

        // Phase tracking from release: period 10 for DIV=4, 8 for DIV=3.
        for (int i = 0; i < 20; i++) begin
            int p1, p2;
            if (i > 0) tick();
            p1 = i % 10;
            p2 = i % 8;
            check($sformatf("ph4_%0d_an4", i), {31'd0, an4_1}, {31'd0, !(p1 < 4)});
            check($sformatf("ph4_%0d_an3", i), {31'd0, an3_1}, {31'd0, !(p1 >= 5 && p1 <= 8)});
            check($sformatf("ph3_%0d_an4", i), {31'd0, an4_2}, {31'd0, !(p2 < 3)});
            check($sformatf("ph3_%0d_an3", i), {31'd0, an3_2}, {31'd0, !(p2 >= 4 && p2 <= 6)});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
